multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Multi-cycle sequencer for the 16-opcode, 4-bit ISA datapath (PC, IR, register file, ALU, data memory).
- Steps each instruction through IF/ID/EXE/MEM/WB and drives the existing datapath control signals per state.
- Adds wait-state handling for data memory, with a timeout.
- Replaces per-opcode single-cycle decode; instructions now take 2–5+ cycles.

Parameters:
- MEM_TIMEOUT, 15, maximum data-memory wait cycles in MEM before bus error (1..255).

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- Reset  input  1  synchronous reset, active-low: 0 at a rising edge resets.
- opcode  input  4  instruction bits [31:28] from IR; sampled at IF→ID edge only.
- zero  input  1  ALU zero flag.
- sign  input  1  ALU sign flag.
- mem_ready  input  1  data memory completion, level; valid in MEM states.
- PCWre  output  1  PC write enable; one-cycle pulse at instruction retire.
- IRWre  output  1  IR load enable.
- InsMemRW  output  1  instruction memory read (1 = read).
- ALUSrcA  output  1  ALU A source select.
- ALUSrcB  output  1  ALU B source select.
- DBDataSrc  output  1  write-back source (0 = ALU, 1 = data memory).
- RegWre  output  1  register file write enable.
- RegDst  output  1  destination register (1 = rd, 0 = rt).
- ExtSel  output  1  immediate extension (1 = sign, 0 = zero).
- RD  output  1  data memory read, active-low.
- WR  output  1  data memory write, active-low.
- PCSrc  output  2  next-PC select: 00 = +4, 01 = branch, 10 = jump.
- ALUOp  output  3  ALU function code.
- state_o  output  4  current state encoding, for debug and bench.
- instr_done  output  1  equals PCWre; retire strobe.
- halted  output  1  high in HALT.
- bus_err  output  1  sticky; set on memory timeout.

Behaviour:

Opcode map:
- 0000 add, 0001 addi, 0010 sub, 0011 or, 0100 ori, 0101 and, 0110 sll, 0111 slt
- 1000 mov, 1001 movi, 1010 sw, 1011 lw, 1100 beq, 1101 bgtz, 1110 j, 1111 halt

ALUOp encoding:
- add 000, sub 001, sll 010, or 011, and 100, slt 110, mov 111.
- addi/lw/sw use 000; beq/bgtz use 001; ori uses 011; movi uses 111.

Default (safe) output values, applied in every state unless overridden:
- PCWre=0, IRWre=0, RegWre=0, RD=1, WR=1, InsMemRW=1.
- All other outputs 0; PCSrc=00.
- The same safe values are forced combinationally whenever Reset=0.

Reset:
- Reset=0 at an edge: state←IF, op_q←0000, wait counter←0, bus_err←0.
- Applies from any state, including mid-MEM; memory strobes drop the same cycle Reset is low.

States: IF, ID, EXE_ALU, EXE_BR, EXE_MEM, MEM_RD, MEM_WR, WB_ALU, WB_LD, HALT.

Per-state transitions and outputs:
- IF: IRWre=1 → ID. op_q←opcode at this edge.
- ID (decodes op_q):
  - j: PCSrc=10, PCWre=1 → IF.
  - halt → HALT.
  - beq/bgtz → EXE_BR.
  - sw/lw → EXE_MEM.
  - else → EXE_ALU.
- EXE_ALU: ALUSrcA/ALUSrcB/ExtSel/ALUOp per op.
  - sll: ALUSrcA=1.
  - addi/ori/movi: ALUSrcB=1.
  - ExtSel=0 for ori only.
  - → WB_ALU.
- WB_ALU: EXE_ALU signals held.
  - RegWre=1; RegDst=1 for R-type (add, sub, or, and, sll, slt, mov), 0 otherwise.
  - PCWre=1 → IF.
- EXE_BR: ALUOp=001, ExtSel=1, PCWre=1 → IF.
  - PCSrc=01 if (beq and zero=1) or (bgtz and zero=0 and sign=0); else 00.
  - Flags sampled combinationally this cycle.
- EXE_MEM: ALUSrcB=1, ExtSel=1, ALUOp=000 → MEM_WR (sw) or MEM_RD (lw). Counter←0.
- MEM_RD / MEM_WR: address controls held; RD=0 (MEM_RD) or WR=0 (MEM_WR).
  - mem_ready=1:
    - MEM_RD → WB_LD.
    - MEM_WR: PCWre=1 → IF.
  - mem_ready=0: counter++ and stay.
  - Counter reaches MEM_TIMEOUT with mem_ready still 0: bus_err←1 → HALT.
  - mem_ready=1 on the same cycle as the counter reaching MEM_TIMEOUT: success wins.
- WB_LD: DBDataSrc=1, RegWre=1, RegDst=0, RD=0, PCWre=1 → IF.
- HALT: all outputs at safe values, halted=1. Exit only via Reset.

Cycle counts with mem_ready=1 on first MEM cycle:
- j: 2
- beq/bgtz: 3
- ALU ops: 4
- sw: 4
- lw: 5
- Each wait cycle adds 1.

Additional rules:
- Exactly one PCWre pulse per instruction; never asserted in IF.
- Unreachable state encodings → IF.

Decomposition:
- cpu_pkg holds:
  - opcode localparams;
  - ALUOp codes;
  - PCSrc codes;
  - state encodings (4-bit).
- One sub-module, mc_ctrl_decode: purely combinational; maps (state, op_q, zero, sign) to the control word. The top level keeps the state register, op_q, wait counter and bus_err.

Test Plan:
- Reset low 2 cycles, then high; opcode=0000, mem_ready=1 → states IF,ID,EXE_ALU,WB_ALU; RegWre=1 and RegDst=1 in WB_ALU; PCWre pulse on cycle 4 only; ALUOp=000.
- opcode=1011, mem_ready low 2 cycles then high → RD=0 for 3 MEM_RD cycles; WB_LD with DBDataSrc=1, RegWre=1; retire on cycle 7.
- opcode=1100 with zero=1 → PCSrc=01 and PCWre=1 in cycle 3. Repeat with opcode=1101, zero=0, sign=1 → PCSrc=00.
- opcode=1110 → PCSrc=10 and PCWre=1 in ID; back to IF on cycle 3. opcode=1111 → halted=1, PCWre stays 0 for 20 cycles.
- opcode=1010 with mem_ready held 0, MEM_TIMEOUT=3 → WR=0 for 4 cycles, then bus_err=1 and HALT. Reset clears both.
- Reset=0 asserted in MEM_WR → WR=1 the same cycle; state IF after the edge; next instruction runs normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle control unit:
// opcodes, ALU/PC select codes, FSM states and the control word.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ORI  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MOV  = 4'b1000;
  localparam logic [3:0] OP_MOVI = 4'b1001;
  localparam logic [3:0] OP_SW   = 4'b1010;
  localparam logic [3:0] OP_LW   = 4'b1011;
  localparam logic [3:0] OP_BEQ  = 4'b1100;
  localparam logic [3:0] OP_BGTZ = 4'b1101;
  localparam logic [3:0] OP_J    = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_MOV = 3'b111;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EXE_ALU = 4'd2,
    S_EXE_BR  = 4'd3,
    S_EXE_MEM = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_WB_ALU  = 4'd7,
    S_WB_LD   = 4'd8,
    S_HALT    = 4'd9
  } state_t;

  typedef struct packed {
    logic       pcWre;
    logic       irWre;
    logic       insMemRw;
    logic       aluSrcA;
    logic       aluSrcB;
    logic       dbDataSrc;
    logic       regWre;
    logic       regDst;
    logic       extSel;
    logic       rdN;
    logic       wrN;
    logic [1:0] pcSrc;
    logic [2:0] aluOp;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam ctrl_t CTRL_SAFE = '{
    pcWre:     1'b0,
    irWre:     1'b0,
    insMemRw:  1'b1,
    aluSrcA:   1'b0,
    aluSrcB:   1'b0,
    dbDataSrc: 1'b0,
    regWre:    1'b0,
    regDst:    1'b0,
    extSel:    1'b0,
    rdN:       1'b1,
    wrN:       1'b1,
    pcSrc:     PC_INC,
    aluOp:     ALU_ADD
  };

  function automatic logic [2:0] aluOpOf(
    input logic [3:0] op
  );
    case (op)
      OP_SUB, OP_BEQ, OP_BGTZ: return ALU_SUB;
      OP_SLL:                  return ALU_SLL;
      OP_OR, OP_ORI:           return ALU_OR;
      OP_AND:                  return ALU_AND;
      OP_SLT:                  return ALU_SLT;
      OP_MOV, OP_MOVI:         return ALU_MOV;
      default:                 return ALU_ADD;
    endcase
  endfunction

  function automatic logic isRType(
    input logic [3:0] op
  );
    return op inside {OP_ADD, OP_SUB, OP_OR,
                      OP_AND, OP_SLL, OP_SLT,
                      OP_MOV};
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode from FSM state,
// latched opcode and ALU flags.
module mc_ctrl_decode
  import cpu_pkg::*;
(
  input  logic [3:0]        state,
  input  logic [3:0]        opQ,
  input  logic              zero,
  input  logic              sign,
  output logic [CTRL_W-1:0] ctrl
);

  state_t st;
  ctrl_t  c;
  logic   taken;

  assign st = state_t'(state);
  assign ctrl = c;

  assign taken = (opQ == OP_BEQ && zero) ||
                 (opQ == OP_BGTZ && !zero && !sign);

  always_comb begin
    c = CTRL_SAFE;
    unique case (st)
      S_IF: c.irWre = 1'b1;
      S_ID: begin
        if (opQ == OP_J) begin
          c.pcSrc = PC_JMP;
          c.pcWre = 1'b1;
        end
      end
      S_EXE_ALU, S_WB_ALU: begin
        c.aluSrcA = (opQ == OP_SLL);
        c.aluSrcB = opQ inside {OP_ADDI, OP_ORI,
                                OP_MOVI};
        c.extSel  = (opQ != OP_ORI);
        c.aluOp   = aluOpOf(opQ);
        if (st == S_WB_ALU) begin
          c.regWre = 1'b1;
          c.regDst = isRType(opQ);
          c.pcWre  = 1'b1;
        end
      end
      S_EXE_BR: begin
        c.aluOp  = ALU_SUB;
        c.extSel = 1'b1;
        c.pcWre  = 1'b1;
        c.pcSrc  = taken ? PC_BR : PC_INC;
      end
      S_EXE_MEM, S_MEM_RD, S_MEM_WR: begin
        c.aluSrcB = 1'b1;
        c.extSel  = 1'b1;
        c.aluOp   = ALU_ADD;
        c.rdN     = (st != S_MEM_RD);
        c.wrN     = (st != S_MEM_WR);
      end
      S_WB_LD: begin
        c.dbDataSrc = 1'b1;
        c.regWre    = 1'b1;
        c.rdN       = 1'b0;
        c.pcWre     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer with
// data-memory wait states and a bus-error timeout.
module multicycle_control_fsm
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       sign,
  input  logic       mem_ready,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       DBDataSrc,
  output logic       RegWre,
  output logic       RegDst,
  output logic       ExtSel,
  output logic       RD,
  output logic       WR,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp,
  output logic [3:0] state_o,
  output logic       instr_done,
  output logic       halted,
  output logic       bus_err
);

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t     state, stateNext;
  logic [3:0] opQ;
  logic [7:0] waitCnt, cntNext;
  logic       errSet;
  logic       wrRetire;
  ctrl_t      dec, c;

  mc_ctrl_decode u_dec (
    .state (state),
    .opQ   (opQ),
    .zero  (zero),
    .sign  (sign),
    .ctrl  (dec)
  );

  always_comb begin
    stateNext = S_IF;
    cntNext   = waitCnt;
    errSet    = 1'b0;
    unique case (state)
      S_IF: stateNext = S_ID;
      S_ID: begin
        unique case (1'b1)
          opQ == OP_J:    stateNext = S_IF;
          opQ == OP_HALT: stateNext = S_HALT;
          opQ == OP_BEQ,
          opQ == OP_BGTZ: stateNext = S_EXE_BR;
          opQ == OP_SW,
          opQ == OP_LW:   stateNext = S_EXE_MEM;
          default:        stateNext = S_EXE_ALU;
        endcase
      end
      S_EXE_ALU: stateNext = S_WB_ALU;
      S_WB_ALU:  stateNext = S_IF;
      S_EXE_BR:  stateNext = S_IF;
      S_EXE_MEM: begin
        stateNext = (opQ == OP_SW) ? S_MEM_WR : S_MEM_RD;
        cntNext   = 8'd0;
      end
      S_MEM_RD, S_MEM_WR: begin
        // a late ready still wins over the timeout
        if (mem_ready) begin
          stateNext = (state == S_MEM_RD) ? S_WB_LD : S_IF;
        end else if (waitCnt >= TMO) begin
          stateNext = S_HALT;
          errSet    = 1'b1;
        end else begin
          stateNext = state;
          cntNext   = waitCnt + 8'd1;
        end
      end
      S_WB_LD: stateNext = S_IF;
      S_HALT:  stateNext = S_HALT;
      default: stateNext = S_IF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state   <= S_IF;
      opQ     <= 4'b0000;
      waitCnt <= 8'd0;
      bus_err <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= cntNext;
      if (state == S_IF) opQ <= opcode;
      if (errSet) bus_err <= 1'b1;
    end
  end

  assign c = Reset ? dec : CTRL_SAFE;
  assign wrRetire = Reset && state == S_MEM_WR && mem_ready;

  assign PCWre      = c.pcWre | wrRetire;
  assign instr_done = PCWre;
  assign IRWre      = c.irWre;
  assign InsMemRW   = c.insMemRw;
  assign ALUSrcA    = c.aluSrcA;
  assign ALUSrcB    = c.aluSrcB;
  assign DBDataSrc  = c.dbDataSrc;
  assign RegWre     = c.regWre;
  assign RegDst     = c.regDst;
  assign ExtSel     = c.extSel;
  assign RD         = c.rdN;
  assign WR         = c.wrN;
  assign PCSrc      = c.pcSrc;
  assign ALUOp      = c.aluOp;
  assign state_o    = state;
  assign halted     = (state == S_HALT);

endmodule
